pid_core_seq: RTL and testbench
===============================

Name: pid_core_seq

Overview:
- Parametrised successor to the fan-controller PID core.
- Computes the second-order IIR control law y[n] = b2·e[n] + b1·e[n-1] + b0·e[n-2] − a1·y[n-1] − a0·y[n-2], with e = SET − ADC.
- Uses one time-multiplexed multiplier under a small FSM instead of five parallel multipliers, so it fits the TinyTapeout area budget.
- Adds a busy/valid handshake, a coefficient snapshot, output saturation with clamped history (anti-windup), a history clear and an overrun flag. It sits between the ADC sampler and the PWM generator.

Parameters:
- ADC_BITWIDTH, 8, width of the unsigned ADC and setpoint values.
- REG_BITWIDTH, 8, width of the signed coefficient registers.
- FRAC_BITWIDTH, 4, fractional bits of the coefficients (1.0 = 2^FRAC_BITWIDTH).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  reset, synchronous, active-low.
- dataValid_STRB_i  in  1  one-cycle strobe requesting a new sample computation.
- clear_i  in  1  synchronous clear of history and overrun_o; lower priority than rstn_i.
- ADC_value_i  in  ADC_BITWIDTH  unsigned measured value.
- SET_value_i  in  ADC_BITWIDTH  unsigned setpoint.
- a1_reg_i, a0_reg_i, b0_reg_i, b1_reg_i, b2_reg_i  in  REG_BITWIDTH each  signed fixed-point coefficients.
- out_Val_o  out  ADC_BITWIDTH+1  signed saturated controller output.
- outValid_STRB_o  out  1  one-cycle pulse when out_Val_o updates.
- busy_o  out  1  high while a computation is in progress.
- sat_o  out  1  high when the last result was clamped.
- overrun_o  out  1  sticky flag: a strobe arrived while busy.

Behaviour:
- Reset:
  - Sampled only on clk_i edges with rstn_i low; there is no asynchronous path.
  - All outputs go to 0, FSM goes to IDLE, and e[n-1], e[n-2], y[n-1], y[n-2] and the accumulator go to 0.
- Widths:
  - e = SET − ADC is signed ADC_BITWIDTH+1 bits.
  - Stored y history is signed ADC_BITWIDTH+1 bits (post-saturation integer).
  - Accumulator ACC_W = ADC_BITWIDTH+REG_BITWIDTH+4 bits, signed; no internal overflow is possible.
- FSM states: IDLE → MAC_B2 → MAC_B1 → MAC_B0 → MAC_A1 → MAC_A0 → SAT → IDLE.
- Edge E0 (IDLE with strobe high): latch e[n], snapshot all five coefficients, clear acc, go to MAC_B2.
- Edges E1..E5, one product per edge:
  - E1: acc += b2·e[n]
  - E2: acc += b1·e[n-1]
  - E3: acc += b0·e[n-2]
  - E4: acc −= a1·y[n-1]
  - E5: acc −= a0·y[n-2]
- Edge E6 (SAT):
  - r = acc >>> FRAC_BITWIDTH (arithmetic, floor).
  - Clamp r to [−2^ADC_BITWIDTH, 2^ADC_BITWIDTH − 1]; sat_o = 1 if clamped, else 0.
  - out_Val_o = clamped r. The clamped value (not r) is written into y[n-1], and the old y[n-1] moves to y[n-2].
  - e[n] moves to e[n-1], and e[n-1] moves to e[n-2].
  - outValid_STRB_o is high for exactly the cycle after E6; the FSM returns to IDLE.
- Latency: 6 clock edges from strobe sample to output update. Throughput is one sample per 7 cycles; a strobe is accepted in the first IDLE cycle after SAT.
- busy_o is high in every non-IDLE state.
- Strobe while busy: ignored (no restart, result unaffected) and overrun_o is set. overrun_o is cleared only by reset or clear_i.
- Coefficient or ADC/SET changes after E0 do not affect the running computation.
- clear_i:
  - In IDLE: zeroes the history and overrun_o; out_Val_o holds its value.
  - While busy: aborts to IDLE, zeroes the history, and no valid pulse is issued.
  - clear_i together with a strobe in IDLE: clear wins and the strobe is dropped.
- Reset mid-computation: immediate return to IDLE with all state zero; no valid pulse.

Test Plan:
1. P-only: b2=16, others 0; SET=100, ADC=60, strobe → after 6 edges out_Val_o=40, outValid_STRB_o a single 1-cycle pulse, sat_o=0, busy_o high for exactly 6 cycles.
2. Integrator: b2=16, a1=−16; SET−ADC=10, strobe every 8 cycles → outputs 10, 20, …, 250, then 255 with sat_o=1. Then set e=−10 → next output 245, showing no windup.
3. Negative clamp: b2=32, SET=0, ADC=255 → out_Val_o=−256, sat_o=1.
4. Floor rounding: b2=8 (0.5), SET=0, ADC=3 → product −24 >>> 4 gives out_Val_o=−2.
5. Overrun: strobe at E0 and again at E2 with different ADC → only one valid pulse, result from the E0 data, overrun_o=1 until clear_i.
6. Reset mid-op: rstn_i low at edge E3 → busy_o=0, out_Val_o=0, no valid pulse. Next strobe with b2=16, e=5 → out 5, showing history was zeroed.

Source files
------------

// File: rtl/pid_core_seq.sv
// Second-order IIR PID law evaluated with one shared multiplier over six cycles,
// with saturation, clamped history (anti-windup), abortable clear and overrun flag.
module pid_core_seq #(
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 8,
  parameter int FRAC_BITWIDTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           dataValid_STRB_i,
  input  logic                           clear_i,
  input  logic        [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic        [ADC_BITWIDTH-1:0] SET_value_i,
  input  logic signed [REG_BITWIDTH-1:0] a1_reg_i,
  input  logic signed [REG_BITWIDTH-1:0] a0_reg_i,
  input  logic signed [REG_BITWIDTH-1:0] b0_reg_i,
  input  logic signed [REG_BITWIDTH-1:0] b1_reg_i,
  input  logic signed [REG_BITWIDTH-1:0] b2_reg_i,
  output logic signed [ADC_BITWIDTH:0]   out_Val_o,
  output logic                           outValid_STRB_o,
  output logic                           busy_o,
  output logic                           sat_o,
  output logic                           overrun_o
);

  localparam int E_W    = ADC_BITWIDTH + 1;
  localparam int ACC_W  = ADC_BITWIDTH + REG_BITWIDTH + 4;
  localparam int PROD_W = REG_BITWIDTH + E_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< ADC_BITWIDTH) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< ADC_BITWIDTH));

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC_B2,
    S_MAC_B1,
    S_MAC_B0,
    S_MAC_A1,
    S_MAC_A0,
    S_SAT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic signed [E_W-1:0]          r_e0;
  logic signed [E_W-1:0]          r_e1;
  logic signed [E_W-1:0]          r_e2;
  logic signed [E_W-1:0]          r_y1;
  logic signed [E_W-1:0]          r_y2;
  logic signed [REG_BITWIDTH-1:0] r_b2;
  logic signed [REG_BITWIDTH-1:0] r_b1;
  logic signed [REG_BITWIDTH-1:0] r_b0;
  logic signed [REG_BITWIDTH-1:0] r_a1;
  logic signed [REG_BITWIDTH-1:0] r_a0;
  logic signed [ACC_W-1:0]        r_acc;
  logic signed [E_W-1:0]          r_out;
  logic                           r_outValid;
  logic                           r_sat;
  logic                           r_overrun;

  logic signed [E_W-1:0]          w_err;
  logic signed [REG_BITWIDTH-1:0] w_mulCoef;
  logic signed [E_W-1:0]          w_mulData;
  logic                           w_subtract;
  logic signed [PROD_W-1:0]       w_prod;
  logic signed [ACC_W-1:0]        w_prodExt;
  logic signed [ACC_W-1:0]        w_shifted;
  logic signed [E_W-1:0]          w_clamped;
  logic                           w_clip;

  assign w_err = $signed({1'b0, SET_value_i}) - $signed({1'b0, ADC_value_i});

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (dataValid_STRB_i) w_nextState = S_MAC_B2;
      S_MAC_B2: w_nextState = S_MAC_B1;
      S_MAC_B1: w_nextState = S_MAC_B0;
      S_MAC_B0: w_nextState = S_MAC_A1;
      S_MAC_A1: w_nextState = S_MAC_A0;
      S_MAC_A0: w_nextState = S_SAT;
      S_SAT:    w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
    if (clear_i) w_nextState = S_IDLE;
  end

  // Each MAC state routes one coefficient/history pair through the shared multiplier.
  always_comb begin
    w_mulCoef  = '0;
    w_mulData  = '0;
    w_subtract = 1'b0;
    case (r_state)
      S_MAC_B2: begin w_mulCoef = r_b2; w_mulData = r_e0; end
      S_MAC_B1: begin w_mulCoef = r_b1; w_mulData = r_e1; end
      S_MAC_B0: begin w_mulCoef = r_b0; w_mulData = r_e2; end
      S_MAC_A1: begin w_mulCoef = r_a1; w_mulData = r_y1; w_subtract = 1'b1; end
      S_MAC_A0: begin w_mulCoef = r_a0; w_mulData = r_y2; w_subtract = 1'b1; end
      default: ;
    endcase
  end

  assign w_prod    = PROD_W'(w_mulCoef) * PROD_W'(w_mulData);
  assign w_prodExt = ACC_W'(w_prod);
  assign w_shifted = r_acc >>> FRAC_BITWIDTH;

  always_comb begin
    w_clamped = w_shifted[E_W-1:0];
    w_clip    = 1'b0;
    if (w_shifted > SAT_MAX) begin
      w_clamped = {1'b0, {ADC_BITWIDTH{1'b1}}};
      w_clip    = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_clamped = {1'b1, {ADC_BITWIDTH{1'b0}}};
      w_clip    = 1'b1;
    end
  end

  // Clear is evaluated last so it overrides both overrun setting and any state step.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_e0       <= '0;
      r_e1       <= '0;
      r_e2       <= '0;
      r_y1       <= '0;
      r_y2       <= '0;
      r_b2       <= '0;
      r_b1       <= '0;
      r_b0       <= '0;
      r_a1       <= '0;
      r_a0       <= '0;
      r_acc      <= '0;
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_sat      <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_outValid <= 1'b0;
      if (dataValid_STRB_i && (r_state != S_IDLE)) r_overrun <= 1'b1;
      if (clear_i) begin
        r_e0      <= '0;
        r_e1      <= '0;
        r_e2      <= '0;
        r_y1      <= '0;
        r_y2      <= '0;
        r_acc     <= '0;
        r_overrun <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (dataValid_STRB_i) begin
              r_e0  <= w_err;
              r_b2  <= b2_reg_i;
              r_b1  <= b1_reg_i;
              r_b0  <= b0_reg_i;
              r_a1  <= a1_reg_i;
              r_a0  <= a0_reg_i;
              r_acc <= '0;
            end
          end
          S_MAC_B2, S_MAC_B1, S_MAC_B0, S_MAC_A1, S_MAC_A0: begin
            r_acc <= w_subtract ? (r_acc - w_prodExt) : (r_acc + w_prodExt);
          end
          S_SAT: begin
            r_out      <= w_clamped;
            r_sat      <= w_clip;
            r_outValid <= 1'b1;
            r_y2       <= r_y1;
            r_y1       <= w_clamped;
            r_e2       <= r_e1;
            r_e1       <= r_e0;
          end
          default: ;
        endcase
      end
    end
  end

  assign out_Val_o       = r_out;
  assign outValid_STRB_o = r_outValid;
  assign busy_o          = (r_state != S_IDLE);
  assign sat_o           = r_sat;
  assign overrun_o       = r_overrun;

endmodule

// File: tb/tb_pid_core_seq.sv
// Randomised scoreboard bench for pid_core_seq: the stimulus side pushes results of a
// plain-arithmetic control-law model, a monitor pops them whenever a valid pulse appears.
module tb_pid_core_seq;

  localparam int FRAC = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic strobe = 1'b0;
  logic clear = 1'b0;
  logic [7:0] adcVal = '0;
  logic [7:0] setVal = '0;
  logic signed [7:0] a1Reg = '0;
  logic signed [7:0] a0Reg = '0;
  logic signed [7:0] b0Reg = '0;
  logic signed [7:0] b1Reg = '0;
  logic signed [7:0] b2Reg = '0;
  logic signed [8:0] outVal;
  logic outValid;
  logic busy;
  logic sat;
  logic overrun;

  int total = 0;
  int bad = 0;

  typedef struct {
    int val;
    bit sat;
  } exp_t;
  exp_t expQ[$];

  int mE1 = 0, mE2 = 0, mY1 = 0, mY2 = 0, mLastOut = 0;
  bit prevValid = 1'b0;

  pid_core_seq #(.ADC_BITWIDTH(8), .REG_BITWIDTH(8), .FRAC_BITWIDTH(FRAC)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .dataValid_STRB_i(strobe),
    .clear_i(clear),
    .ADC_value_i(adcVal),
    .SET_value_i(setVal),
    .a1_reg_i(a1Reg),
    .a0_reg_i(a0Reg),
    .b0_reg_i(b0Reg),
    .b1_reg_i(b1Reg),
    .b2_reg_i(b2Reg),
    .out_Val_o(outVal),
    .outValid_STRB_o(outValid),
    .busy_o(busy),
    .sat_o(sat),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelClear();
    mE1 = 0; mE2 = 0; mY1 = 0; mY2 = 0;
  endtask

  // y = (b2 e + b1 e1 + b0 e2 - a1 y1 - a0 y2) / 2^FRAC, floored, then clamped to 9 bits.
  task automatic modelStep(input int e0, input int cb2, input int cb1, input int cb0,
                           input int ca1, input int ca0);
    int acc, r, y;
    exp_t item;
    acc = cb2 * e0 + cb1 * mE1 + cb0 * mE2 - ca1 * mY1 - ca0 * mY2;
    r = acc >>> FRAC;
    y = (r > 255) ? 255 : ((r < -256) ? -256 : r);
    item.val = y;
    item.sat = (y != r);
    expQ.push_back(item);
    mY2 = mY1; mY1 = y;
    mE2 = mE1; mE1 = e0;
    mLastOut = y;
  endtask

  // Called on a falling edge; the strobe is sampled at the following rising edge.
  task automatic applyStimulus(input int setV, input int adcV, input int cb2, input int cb1,
                               input int cb0, input int ca1, input int ca0, input bit expectRun);
    setVal = 8'(setV);
    adcVal = 8'(adcV);
    b2Reg = 8'(cb2);
    b1Reg = 8'(cb1);
    b0Reg = 8'(cb0);
    a1Reg = 8'(ca1);
    a0Reg = 8'(ca0);
    strobe = 1'b1;
    if (expectRun) modelStep(setV - adcV, cb2, cb1, cb0, ca1, ca0);
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    modelClear();
  endtask

  always @(negedge clk) begin
    if (outValid) begin
      checkOutput("validPulseWidth", int'(prevValid), 0);
      checkOutput("expectedResultPending", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        exp_t item;
        item = expQ.pop_front();
        checkOutput("outVal", int'(outVal), item.val);
        checkOutput("sat", int'(sat), int'(item.sat));
      end
    end
    prevValid = outValid;
  end

  initial begin
    int busyCnt, validCnt, rb2, rb1, rb0, ra1, ra0;

    idleCycles(2);
    checkOutput("resetOut", int'(outVal), 0);
    checkOutput("resetValid", int'(outValid), 0);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetSat", int'(sat), 0);
    checkOutput("resetOverrun", int'(overrun), 0);
    rstn = 1'b1;
    idleCycles(1);

    // P-only: busy for exactly six cycles and a single valid pulse
    applyStimulus(100, 60, 16, 0, 0, 0, 0, 1);
    busyCnt = 0;
    validCnt = 0;
    for (int i = 0; i < 8; i++) begin
      busyCnt += int'(busy);
      validCnt += int'(outValid);
      @(negedge clk);
    end
    checkOutput("busyCycles", busyCnt, 6);
    checkOutput("validPulses", validCnt, 1);

    // Integrator ramps to saturation then steps back without windup
    pulseClear();
    for (int i = 0; i < 26; i++) begin
      applyStimulus(110, 100, 16, 0, 0, -16, 0, 1);
      idleCycles(7);
    end
    applyStimulus(90, 100, 16, 0, 0, -16, 0, 1);
    idleCycles(7);

    // Negative clamp and floor rounding
    applyStimulus(0, 255, 32, 0, 0, 0, 0, 1);
    idleCycles(7);
    applyStimulus(0, 3, 8, 0, 0, 0, 0, 1);
    idleCycles(7);

    // Overrun: second strobe at E2 with new data must be ignored
    applyStimulus(100, 60, 16, 0, 0, 0, 0, 1);
    @(negedge clk);
    adcVal = 8'd0;
    b2Reg = 8'sd127;
    a1Reg = -8'sd50;
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    checkOutput("overrunSet", int'(overrun), 1);
    idleCycles(6);
    checkOutput("overrunSticky", int'(overrun), 1);
    checkOutput("busyAfterOverrunRun", int'(busy), 0);
    pulseClear();
    checkOutput("overrunCleared", int'(overrun), 0);
    checkOutput("outHoldOnClear", int'(outVal), mLastOut);

    // Clear while busy aborts and wipes history
    applyStimulus(120, 100, 16, 0, 0, 0, 0, 1);
    idleCycles(7);
    applyStimulus(120, 20, 16, 0, 0, 0, 0, 0);
    @(negedge clk);
    pulseClear();
    checkOutput("busyAfterAbort", int'(busy), 0);
    idleCycles(8);
    applyStimulus(105, 100, 16, 16, 0, -16, 0, 1);
    idleCycles(7);

    // Clear together with a strobe in IDLE drops the strobe
    clear = 1'b1;
    strobe = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    strobe = 1'b0;
    modelClear();
    checkOutput("busyClearWinsStrobe", int'(busy), 0);
    idleCycles(8);

    // Reset at E3 mid-computation
    applyStimulus(120, 100, 16, 0, 0, 0, 0, 1);
    idleCycles(7);
    applyStimulus(150, 50, 16, 0, 0, 0, 0, 0);
    idleCycles(2);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    modelClear();
    checkOutput("busyAfterReset", int'(busy), 0);
    checkOutput("outAfterReset", int'(outVal), 0);
    checkOutput("satAfterReset", int'(sat), 0);
    idleCycles(8);
    applyStimulus(105, 100, 16, 16, 0, -16, 0, 1);
    idleCycles(7);

    // Randomised coefficients and samples with occasional history clears
    pulseClear();
    for (int i = 0; i < 40; i++) begin
      rb2 = int'($urandom_range(0, 255)) - 128;
      rb1 = int'($urandom_range(0, 255)) - 128;
      rb0 = int'($urandom_range(0, 255)) - 128;
      ra1 = int'($urandom_range(0, 255)) - 128;
      ra0 = int'($urandom_range(0, 255)) - 128;
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    rb2, rb1, rb0, ra1, ra0, 1);
      idleCycles(7 + int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) pulseClear();
    end

    idleCycles(20);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
